// File: rtl/alarm_arm_controller.sv
// Arming sequencer behind the alarm detector: exit/entry delays, instant zones, zone memory, siren blink.
// Optional siren timeout back to ARMED is enabled by defining ALARM_SIREN_TIMEOUT_EN.
//
// state        | meaning
// DISARMED (0) | idle, waiting for arm switch
// EXIT_DELAY(1)| occupant leaving, triggers ignored
// ARMED (2)    | watching for triggers
// ENTRY_DELAY(3)| delayed zone tripped, countdown to siren
// ALARM (4)    | siren blinking
module alarm_arm_controller #(
  parameter int unsigned TICK_DIV     = 100000000,
  parameter int unsigned EXIT_TICKS   = 10,
  parameter int unsigned ENTRY_TICKS  = 5,
  parameter int unsigned SIREN_TICKS  = 180,
  parameter logic [3:0]  INSTANT_MASK = 4'b1110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m,
  input  logic       a,
  input  logic [3:0] sw,
  output logic       siren,
  output logic       armed_led,
  output logic       delay_led,
  output logic [3:0] zone,
  output logic [2:0] st
);

  localparam int unsigned MAX_AB    = (EXIT_TICKS > ENTRY_TICKS) ? EXIT_TICKS : ENTRY_TICKS;
  localparam int unsigned MAX_TICKS = (MAX_AB > SIREN_TICKS) ? MAX_AB : SIREN_TICKS;
  localparam int unsigned SEC_W     = $clog2(MAX_TICKS) + 1;
  localparam int unsigned TICK_W    = $clog2(TICK_DIV);

  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [SEC_W-1:0]  SEC_MAX    = {SEC_W{1'b1}};
  // Expiry fires on the tick that would bring sec_cnt up to the limit, so N ticks last N*TICK_DIV cycles.
  localparam logic [SEC_W-1:0]  EXIT_LAST  = SEC_W'((EXIT_TICKS == 0) ? 0 : EXIT_TICKS - 1);
  localparam logic [SEC_W-1:0]  ENTRY_LAST = SEC_W'((ENTRY_TICKS == 0) ? 0 : ENTRY_TICKS - 1);
`ifdef ALARM_SIREN_TIMEOUT_EN
  localparam logic [SEC_W-1:0]  SIREN_LAST = SEC_W'((SIREN_TICKS == 0) ? 0 : SIREN_TICKS - 1);
`endif

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_t;

  logic              r_m_meta, r_m_s;
  logic              r_a_meta, r_a_s;
  logic [3:0]        r_sw_meta, r_sw_s;
  state_t            r_state;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [SEC_W-1:0]  r_sec_cnt;
  logic              r_siren, r_armed_led, r_delay_led;
  logic [3:0]        r_zone;

  state_t            w_next_state;
  logic              w_tick;
  logic              w_exit_done;
  logic              w_entry_done;
  logic              w_instant;
  logic              w_state_change;
  logic              w_siren_next, w_armed_next, w_delay_next;
  logic [3:0]        w_zone_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_m_meta  <= 1'b0;
      r_m_s     <= 1'b0;
      r_a_meta  <= 1'b0;
      r_a_s     <= 1'b0;
      r_sw_meta <= 4'd0;
      r_sw_s    <= 4'd0;
    end else begin
      r_m_meta  <= m;
      r_m_s     <= r_m_meta;
      r_a_meta  <= a;
      r_a_s     <= r_a_meta;
      r_sw_meta <= sw;
      r_sw_s    <= r_sw_meta;
    end
  end

  assign w_tick         = (r_tick_cnt == TICK_LAST);
  assign w_exit_done    = (EXIT_TICKS == 0) || (w_tick && (r_sec_cnt == EXIT_LAST));
  assign w_entry_done   = (ENTRY_TICKS == 0) || (w_tick && (r_sec_cnt == ENTRY_LAST));
  assign w_instant      = |(r_sw_s & INSTANT_MASK);
  assign w_state_change = (w_next_state != r_state);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_sec_cnt  <= '0;
    end else if (w_state_change) begin
      r_tick_cnt <= '0;
      r_sec_cnt  <= '0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_W'(1);
      if (w_tick && (r_sec_cnt != SEC_MAX)) begin
        r_sec_cnt <= r_sec_cnt + SEC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_DISARMED;
      r_siren     <= 1'b0;
      r_armed_led <= 1'b0;
      r_delay_led <= 1'b0;
      r_zone      <= 4'd0;
    end else begin
      r_state     <= w_next_state;
      r_siren     <= w_siren_next;
      r_armed_led <= w_armed_next;
      r_delay_led <= w_delay_next;
      r_zone      <= w_zone_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (!r_m_s) begin
      w_next_state = S_DISARMED;
    end else begin
      case (r_state)
        S_DISARMED: w_next_state = S_EXIT;
        S_EXIT: begin
          if (w_exit_done) w_next_state = S_ARMED;
        end
        S_ARMED: begin
          if (r_a_s) w_next_state = w_instant ? S_ALARM : S_ENTRY;
        end
        S_ENTRY: begin
          if ((r_a_s && w_instant) || w_entry_done) w_next_state = S_ALARM;
        end
        S_ALARM: begin
`ifdef ALARM_SIREN_TIMEOUT_EN
          if ((SIREN_TICKS == 0) || (w_tick && (r_sec_cnt == SIREN_LAST))) begin
            w_next_state = S_ARMED;
          end
`else
          w_next_state = S_ALARM;
`endif
        end
        default: w_next_state = S_DISARMED;
      endcase
    end
  end

  always_comb begin
    w_zone_next  = r_zone;
    w_siren_next = 1'b0;
    w_delay_next = 1'b0;
    w_armed_next = (w_next_state == S_ARMED) || (w_next_state == S_ENTRY) ||
                   (w_next_state == S_ALARM);
    // Zone is frozen on disarm so the record survives for inspection until re-arming.
    if (r_m_s) begin
      if (r_state == S_DISARMED) begin
        w_zone_next = 4'd0;
      end else if (r_a_s && ((r_state == S_ARMED) || (r_state == S_ENTRY) ||
                             (r_state == S_ALARM))) begin
        w_zone_next = r_zone | r_sw_s;
      end
    end
    if (w_next_state == S_ALARM) begin
      w_siren_next = w_state_change ? 1'b1 : (w_tick ? ~r_siren : r_siren);
    end
    if ((w_next_state == S_EXIT) || (w_next_state == S_ENTRY)) begin
      w_delay_next = w_state_change ? 1'b1 : (w_tick ? ~r_delay_led : r_delay_led);
    end
  end

  assign siren     = r_siren;
  assign armed_led = r_armed_led;
  assign delay_led = r_delay_led;
  assign zone      = r_zone;
  assign st        = r_state;

endmodule

// File: tb/tb_alarm_arm_controller.sv
// Directed plus randomized bench for alarm_arm_controller against an elapsed-time reference model.
module tb_alarm_arm_controller;
  localparam int TICK_DIV    = 4;
  localparam int EXIT_TICKS  = 2;
  localparam int ENTRY_TICKS = 3;
  localparam int SIREN_TICKS = 2;
  localparam logic [3:0] MASK = 4'b1110;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m = 1'b0;
  logic       a = 1'b0;
  logic [3:0] sw = 4'd0;
  logic       siren, armed_led, delay_led;
  logic [3:0] zone;
  logic [2:0] st;

  int checks = 0;
  int errors = 0;

  alarm_arm_controller #(
    .TICK_DIV(TICK_DIV), .EXIT_TICKS(EXIT_TICKS), .ENTRY_TICKS(ENTRY_TICKS),
    .SIREN_TICKS(SIREN_TICKS), .INSTANT_MASK(MASK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .m(m), .a(a), .sw(sw),
    .siren(siren), .armed_led(armed_led), .delay_led(delay_led), .zone(zone), .st(st)
  );

  always #5 clk = ~clk;

  // Reference model: state plus number of edges spent in it; all timing derived from elapsed edges.
  int         md_st = 0;
  int         md_k = 0;
  logic [3:0] md_zone = 4'd0;
  logic       md_siren = 1'b0, md_armed = 1'b0, md_delay = 1'b0;
  logic       md_m1 = 1'b0, md_m2 = 1'b0, md_a1 = 1'b0, md_a2 = 1'b0;
  logic [3:0] md_sw1 = 4'd0, md_sw2 = 4'd0;

  always @(posedge clk) begin
    int ns;
    logic [3:0] z;
    if (!rst_n) begin
      md_st = 0; md_k = 0; md_zone = 4'd0;
      md_siren = 1'b0; md_armed = 1'b0; md_delay = 1'b0;
      md_m1 = 1'b0; md_m2 = 1'b0; md_a1 = 1'b0; md_a2 = 1'b0;
      md_sw1 = 4'd0; md_sw2 = 4'd0;
    end else begin
      ns = md_st;
      z  = md_zone;
      if (!md_m2) begin
        ns = 0;
      end else begin
        if (md_st >= 2 && md_a2) z = z | md_sw2;
        case (md_st)
          0: begin ns = 1; z = 4'd0; end
          1: if (md_k + 1 >= EXIT_TICKS * TICK_DIV) ns = 2;
          2: if (md_a2) ns = ((md_sw2 & MASK) != 0) ? 4 : 3;
          3: if ((md_a2 && (md_sw2 & MASK) != 0) || (md_k + 1 >= ENTRY_TICKS * TICK_DIV)) ns = 4;
          4: begin
`ifdef ALARM_SIREN_TIMEOUT_EN
            if (md_k + 1 >= SIREN_TICKS * TICK_DIV) ns = 2;
`endif
          end
          default: ns = 0;
        endcase
      end
      if (ns != md_st) md_k = 0;
      else md_k = md_k + 1;
      md_st    = ns;
      md_zone  = z;
      md_armed = (ns >= 2);
      md_delay = (ns == 1 || ns == 3) && ((md_k / TICK_DIV) % 2 == 0);
      md_siren = (ns == 4) && ((md_k / TICK_DIV) % 2 == 0);
      md_m2 = md_m1; md_m1 = m;
      md_a2 = md_a1; md_a1 = a;
      md_sw2 = md_sw1; md_sw1 = sw;
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("model_st", {5'd0, st}, md_st[7:0]);
      chk("model_zone", {4'd0, zone}, {4'd0, md_zone});
      chk("model_siren", {7'd0, siren}, {7'd0, md_siren});
      chk("model_armed", {7'd0, armed_led}, {7'd0, md_armed});
      chk("model_delay", {7'd0, delay_led}, {7'd0, md_delay});
    end
  endtask

  task automatic drive(input logic mv, input logic [3:0] swv);
    m  = mv;
    sw = swv;
    a  = mv & (|swv);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'd0);
    cyc(3);
    chk("rst_st", {5'd0, st}, 8'd0);
    chk("rst_siren", {7'd0, siren}, 8'd0);
    chk("rst_armed", {7'd0, armed_led}, 8'd0);
    chk("rst_delay", {7'd0, delay_led}, 8'd0);
    chk("rst_zone", {4'd0, zone}, 8'd0);

    rst_n = 1'b1;
    drive(1'b1, 4'd0);
    cyc(2);  chk("arm_lat2", {5'd0, st}, 8'd0);
    cyc(1);  chk("arm_lat3", {5'd0, st}, 8'd1);
    chk("exit_delay_led", {7'd0, delay_led}, 8'd1);
    cyc(7);  chk("exit_7", {5'd0, st}, 8'd1);
    cyc(1);  chk("exit_8", {5'd0, st}, 8'd2);
    chk("armed_led", {7'd0, armed_led}, 8'd1);

    drive(1'b1, 4'b0001);
    cyc(3);  chk("entry_enter", {5'd0, st}, 8'd3);
    cyc(11); chk("entry_11", {5'd0, st}, 8'd3);
    cyc(1);  chk("entry_12", {5'd0, st}, 8'd4);
    chk("zone_0001", {4'd0, zone}, 8'h01);
    chk("siren_start", {7'd0, siren}, 8'd1);
    cyc(3);  chk("siren_3", {7'd0, siren}, 8'd1);
    cyc(1);  chk("siren_4", {7'd0, siren}, 8'd0);
    cyc(4);  chk("siren_8", {7'd0, siren}, 8'd1);

    drive(1'b0, 4'b0001);
    cyc(2);  chk("disarm_lat2", {5'd0, st}, 8'd4);
    cyc(1);  chk("disarm_lat3", {5'd0, st}, 8'd0);
    chk("disarm_siren", {7'd0, siren}, 8'd0);
    chk("disarm_zone", {4'd0, zone}, 8'h01);

    drive(1'b1, 4'd0);
    cyc(3);  chk("rearm_st", {5'd0, st}, 8'd1);
    chk("rearm_zone", {4'd0, zone}, 8'd0);
    cyc(8);  chk("rearm_armed", {5'd0, st}, 8'd2);

    drive(1'b1, 4'b0100);
    cyc(2);  chk("instant_lat2", {5'd0, st}, 8'd2);
    cyc(1);  chk("instant_st", {5'd0, st}, 8'd4);
    chk("instant_zone", {4'd0, zone}, 8'h04);

    cyc(2);
    rst_n = 1'b0;
    cyc(1);
    chk("midrst_st", {5'd0, st}, 8'd0);
    chk("midrst_siren", {7'd0, siren}, 8'd0);
    chk("midrst_armed", {7'd0, armed_led}, 8'd0);
    chk("midrst_zone", {4'd0, zone}, 8'd0);

    rst_n = 1'b1;
    drive(1'b1, 4'd0);
    cyc(11); chk("rearm2", {5'd0, st}, 8'd2);
    drive(1'b1, 4'b0001);
    cyc(3);  chk("entry2", {5'd0, st}, 8'd3);
    cyc(4);
    drive(1'b1, 4'b1001);
    cyc(2);  chk("early_lat2", {5'd0, st}, 8'd3);
    cyc(1);  chk("early_alarm", {5'd0, st}, 8'd4);
    chk("zone_1001", {4'd0, zone}, 8'h09);

    drive(1'b1, 4'd0);
    cyc(7);  chk("timeout_7", {5'd0, st}, 8'd4);
    cyc(1);
`ifdef ALARM_SIREN_TIMEOUT_EN
    chk("timeout_8", {5'd0, st}, 8'd2);
    chk("timeout_siren", {7'd0, siren}, 8'd0);
    cyc(100); chk("timeout_hold", {5'd0, st}, 8'd2);
`else
    chk("no_timeout_8", {5'd0, st}, 8'd4);
    cyc(100); chk("no_timeout_100", {5'd0, st}, 8'd4);
`endif
    chk("zone_held", {4'd0, zone}, 8'h09);

    drive(1'b0, 4'd0);
    cyc(3);  chk("final_disarm", {5'd0, st}, 8'd0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 79) == 0) m = ~m;
      if ($urandom_range(0, 11) == 0) begin
        sw = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      a = m & (|sw);
      rst_n = ($urandom_range(0, 499) != 0);
      cyc(1);
    end
    rst_n = 1'b1;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alarm_arm_controller.md
Name: alarm_arm_controller

Overview:
- Sequential stage directly downstream of the combinational home alarm detector.
- Consumes the detector's alarm line `a`, the arm switch `m` and the four sensor switches `sw[3:0]`.
- Adds exit delay, entry delay, instant-zone handling, a latched zone memory and a blinking siren drive.
- Outputs drive Basys 3 LEDs directly.

Parameters:
- TICK_DIV, 100000000: clk cycles per delay tick (1 s at 100 MHz); benches use small values.
- EXIT_TICKS, 10: ticks spent in EXIT_DELAY after arming.
- ENTRY_TICKS, 5: ticks spent in ENTRY_DELAY before the siren sounds.
- SIREN_TICKS, 180: siren duration in ticks; used only with the optional feature.
- INSTANT_MASK, 4'b1110: sw bits that skip entry delay and go straight to ALARM.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous reset, active-low
- m  input  1  arm switch level (1 = armed request), asynchronous
- a  input  1  alarm request from detector (m & any sw), asynchronous
- sw  input  4  sensor switches, asynchronous, used for zone capture and instant classification
- siren  output  1  siren/LED drive, toggles each tick while in ALARM
- armed_led  output  1  high in ARMED, ENTRY_DELAY, ALARM
- delay_led  output  1  toggles each tick in EXIT_DELAY and ENTRY_DELAY, else 0
- zone  output  4  sticky record of sw bits seen active while triggered
- st  output  3  state code: 0 DISARMED, 1 EXIT_DELAY, 2 ARMED, 3 ENTRY_DELAY, 4 ALARM

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=DISARMED.
  - Synchronizers, tick_cnt and sec_cnt cleared.
  - All outputs 0, zone=0.
  - Reset mid-delay or mid-alarm aborts immediately.
- Input sync:
  - m, a and sw each pass a 2-flop synchronizer (m_s, a_s, sw_s).
  - Input-to-state-change latency is 3 clk edges: 2 sync plus 1 state register.
- Timebase:
  - tick_cnt counts 0..TICK_DIV-1 and issues a one-cycle tick when tick_cnt == TICK_DIV-1.
  - sec_cnt counts ticks.
  - Both clear on every state transition, so a delay of N ticks lasts exactly N*TICK_DIV cycles after entry.
- Disarm priority: m_s=0 forces DISARMED next cycle from any state. This overrides every other transition, including a simultaneous trigger or delay expiry. zone is retained.
- DISARMED:
  - siren=0, armed_led=0.
  - m_s=1 -> EXIT_DELAY, and zone clears to 0 on this transition.
- EXIT_DELAY:
  - a_s is ignored.
  - sec_cnt reaches EXIT_TICKS -> ARMED.
- ARMED, when a_s=1:
  - zone |= sw_s.
  - If (sw_s & INSTANT_MASK) != 0 -> ALARM, else -> ENTRY_DELAY.
- ENTRY_DELAY:
  - zone |= sw_s while a_s=1.
  - An instant-zone trigger -> ALARM immediately.
  - sec_cnt reaches ENTRY_TICKS -> ALARM.
  - Trigger clearing does not cancel the countdown.
- ALARM:
  - siren starts at 1 on entry and inverts on each tick.
  - zone keeps accumulating while a_s=1.
  - Exit only by disarm, or by the optional timeout.
- Output timing and widths:
  - All outputs are registered; st reflects the current state register.
  - sec_cnt width is clog2 of the max tick parameter + 1.
  - tick_cnt width is clog2(TICK_DIV); TICK_DIV >= 2 is required.
- Edge cases:
  - EXIT_TICKS=0 or ENTRY_TICKS=0 means a one-cycle pass-through state.
  - If sec_cnt saturates, it holds and does not wrap.

Optional Feature:
- Macro: ALARM_SIREN_TIMEOUT_EN.
- Defined:
  - In ALARM, sec_cnt reaching SIREN_TICKS -> ARMED, siren=0, zone retained.
  - If a_s is still 1, the system re-triggers per the ARMED rules.
- Undefined:
  - SIREN_TICKS is unused.
  - ALARM persists until m_s=0 or reset.

Test Plan (all with TICK_DIV=4, EXIT_TICKS=2, ENTRY_TICKS=3, SIREN_TICKS=2):
- Reset, then raise m -> st=1 3 edges later; st=2 exactly 8 cycles after entering EXIT_DELAY; armed_led=1.
- In ARMED, sw=0001 with a=1 -> st=3; st=4 exactly 12 cycles later; zone=0001; siren toggles every 4 cycles starting at 1.
- In ARMED, sw=0100 with a=1 -> st=4 directly with no ENTRY_DELAY; zone=0100.
- In ENTRY_DELAY from sw[0], assert sw[3] -> ALARM before expiry; zone=1001.
- In ALARM, drop m -> st=0 3 edges later, siren=0, zone held; re-arming clears zone to 0.
- With ALARM_SIREN_TIMEOUT_EN defined, ALARM returns to st=2 after 8 cycles. Undefined, st stays 4 for 100 cycles. Pulling rst_n low mid-ALARM gives all outputs 0 on the next edge.
